// File: rtl/lsu_mem_master.sv
// Load/store initiator: byte-addressed requests to word-indexed memory RD/WR cycles, RMW for sub-word stores.
// Latency from acceptance edge: error 1, load/word store 2, sub-word store 3 cycles to resp_valid.
// Backpressure: req_ready only while idle with nothing pending; no pipelining, req_valid ignored when busy.
module lsu_mem_master #(
    parameter int unsigned MEM_WORDS = 8192
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic        mem_RD,
    output logic        mem_WR,
    input  logic [31:0] mem_read_data,
    output logic [31:0] mem_pc
);

    localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t      state;
    logic        pend;
    logic [31:0] l_addr;
    logic [1:0]  l_size;
    logic        l_we;
    logic        l_uns;
    logic [31:0] l_wdata;

    logic        mis_err;
    logic        oor_err;
    logic        req_err;

    // Sub-word store merge: replace the addressed little-endian lane(s) of the old word.
    function automatic logic [31:0] merge_word(input logic [31:0] old_w, input logic [1:0] a,
                                               input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] r;
        r = old_w;
        case (sz)
            SZ_BYTE: r[{a, 3'b000} +: 8]        = wd[7:0];
            SZ_HALF: r[{a[1], 4'b0000} +: 16]   = wd[15:0];
            default: r                          = wd;
        endcase
        return r;
    endfunction

    // Load extraction: select lane/halfword, then sign- or zero-extend.
    function automatic logic [31:0] extract_word(input logic [31:0] w, input logic [1:0] a,
                                                 input logic [1:0] sz, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = w[{a, 3'b000} +: 8];
        h = w[{a[1], 4'b0000} +: 16];
        case (sz)
            SZ_BYTE: r = uns ? {24'h0, b} : {{24{b[7]}}, b};
            SZ_HALF: r = uns ? {16'h0, h} : {{16{h[15]}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

    // Error classification on the latched request, evaluated in the dispatch cycle.
    always_comb begin
        mis_err = (l_size == 2'b11) ||
                  ((l_size == SZ_HALF) && l_addr[0]) ||
                  ((l_size == SZ_WORD) && (l_addr[1:0] != 2'b00));
        oor_err = ({2'b00, l_addr[31:2]} >= MEM_WORDS_W);
        req_err = mis_err || oor_err;
    end

    // A request latched on the acceptance edge is dispatched on the following edge.
    assign req_ready = (state == IDLE) && !pend;

    // Control FSM with registered memory and response outputs. The word read in READ goes
    // straight into resp_rdata (loads) or the merged mem_write_data (sub-word stores), so
    // those registers serve as the read buffer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            pend           <= 1'b0;
            l_addr         <= '0;
            l_size         <= '0;
            l_we           <= 1'b0;
            l_uns          <= 1'b0;
            l_wdata        <= '0;
            resp_valid     <= 1'b0;
            resp_rdata     <= '0;
            resp_err       <= 1'b0;
            mem_addr       <= '0;
            mem_write_data <= '0;
            mem_RD         <= 1'b0;
            mem_WR         <= 1'b0;
            mem_pc         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!pend) begin
                        if (req_valid) begin
                            pend    <= 1'b1;
                            l_addr  <= req_addr;
                            l_size  <= req_size;
                            l_we    <= req_we;
                            l_uns   <= req_unsigned;
                            l_wdata <= req_wdata;
                            mem_pc  <= req_pc;
                        end
                    end else begin
                        pend <= 1'b0;
                        if (req_err) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else if (l_we && (l_size == SZ_WORD)) begin
                            state          <= WRITE;
                            mem_addr       <= {2'b00, l_addr[31:2]};
                            mem_WR         <= 1'b1;
                            mem_write_data <= l_wdata;
                        end else begin
                            // Loads and sub-word stores both start with a read.
                            state    <= READ;
                            mem_addr <= {2'b00, l_addr[31:2]};
                            mem_RD   <= 1'b1;
                        end
                    end
                end
                READ: begin
                    mem_RD <= 1'b0;
                    if (!l_we) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= extract_word(mem_read_data, l_addr[1:0], l_size, l_uns);
                    end else begin
                        state          <= WRITE;
                        mem_WR         <= 1'b1;
                        mem_write_data <= merge_word(mem_read_data, l_addr[1:0], l_size, l_wdata);
                    end
                end
                WRITE: begin
                    mem_WR     <= 1'b0;
                    state      <= RESP;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                end
                RESP: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
